// File: rtl/audio_mixer.sv
// Four-channel APU mixer: masks, sums, scales by master volume and emits one
// registered sample per PWM frame so the DAC never sees a mid-period change.
module audio_mixer #(
  parameter int WIDTH      = 8,
  parameter int SAMPLE_DIV = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       ch1,
  input  logic [3:0]       ch2,
  input  logic [3:0]       ch3,
  input  logic [3:0]       ch4,
  input  logic [3:0]       ch_enable,
  input  logic [2:0]       master_vol,
  input  logic             mute,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_strobe
);

  localparam int CW = $clog2(SAMPLE_DIV);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick;
  logic [3:0]       ch_in    [4];
  logic [3:0]       masked_d [4];
  logic [3:0]       chan_q   [4];
  logic [2:0]       vol_q;
  logic             mute_q;
  logic             v0_q, v1_q, v2_q;
  logic [5:0]       sum_q, sum_d;
  logic [3:0]       gain;
  logic [8:0]       prod_q, prod_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic             strobe_q;

  assign tick  = (cnt_q == CW'(SAMPLE_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  assign ch_in[0] = ch1;
  assign ch_in[1] = ch2;
  assign ch_in[2] = ch3;
  assign ch_in[3] = ch4;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign masked_d[gi] = ch_in[gi] & {4{ch_enable[gi]}};
  end

  assign sum_d = 6'(chan_q[0]) + 6'(chan_q[1]) + 6'(chan_q[2]) + 6'(chan_q[3]);
  assign gain  = {1'b0, vol_q} + 4'd1;
  // Volume and mute stay in the capture registers until the next tick, which
  // is always later than stage 2 because SAMPLE_DIV >= 4.
  assign prod_d = mute_q ? '0 : ({3'b0, sum_q} * {5'b0, gain});
  assign sample_d = WIDTH'(((WIDTH + 1)'(prod_q) << (WIDTH - 8)) >> 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      chan_q   <= '{default: '0};
      vol_q    <= '0;
      mute_q   <= 1'b0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      sum_q    <= '0;
      prod_q   <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      v0_q     <= tick;
      v1_q     <= v0_q;
      v2_q     <= v1_q;
      strobe_q <= v2_q;
      if (tick) begin
        for (int i = 0; i < 4; i++) chan_q[i] <= masked_d[i];
        vol_q  <= master_vol;
        mute_q <= mute;
      end
      if (v0_q) sum_q    <= sum_d;
      if (v1_q) prod_q   <= prod_d;
      if (v2_q) sample_q <= sample_d;
    end
  end

  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: a WIDTH=8 and a WIDTH=10 instance share
// stimulus; expected samples are queued at each capture edge and popped on strobe.
module tb_audio_mixer;

  localparam int DIV = 256;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] ch1, ch2, ch3, ch4, ch_enable;
  logic [2:0] master_vol;
  logic       mute;
  logic [7:0] out8;
  logic [9:0] out10;
  logic       strobe8, strobe10;

  int checks = 0;
  int errors = 0;
  int cnt;
  int q8[$];
  int q10[$];
  int last8 = 0;
  int last10 = 0;

  typedef struct {
    int c1, c2, c3, c4, en, vol, mute, at, glitch, e8, e10;
  } vec_t;
  vec_t vecs[12];
  vec_t vr;

  always #5 clk = ~clk;

  audio_mixer #(.WIDTH(8), .SAMPLE_DIV(DIV)) dut8 (
    .clk(clk), .reset_n(reset_n), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
    .ch_enable(ch_enable), .master_vol(master_vol), .mute(mute),
    .sample_out(out8), .sample_strobe(strobe8)
  );

  audio_mixer #(.WIDTH(10), .SAMPLE_DIV(DIV)) dut10 (
    .clk(clk), .reset_n(reset_n), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
    .ch_enable(ch_enable), .master_vol(master_vol), .mute(mute),
    .sample_out(out10), .sample_strobe(strobe10)
  );

  // Edges since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= 0;
    else          cnt <= cnt + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    ch1 = 4'(v.c1); ch2 = 4'(v.c2); ch3 = 4'(v.c3); ch4 = 4'(v.c4);
    ch_enable = 4'(v.en); master_vol = 3'(v.vol); mute = 1'(v.mute);
  endtask

  task automatic wait_capture();
    do @(negedge clk); while (!(cnt > 0 && cnt % DIV == 0));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int e;
    bit exp_st;
    if (!reset_n) begin
      chk("rst_out8", int'(out8), 0);
      chk("rst_strobe8", int'(strobe8), 0);
      chk("rst_out10", int'(out10), 0);
      chk("rst_strobe10", int'(strobe10), 0);
      q8.delete();
      q10.delete();
      last8 = 0;
      last10 = 0;
    end else begin
      exp_st = (cnt >= DIV + 3) && ((cnt - 3) % DIV == 0);
      chk("strobe8_timing", int'(strobe8), int'(exp_st));
      chk("strobe10_timing", int'(strobe10), int'(exp_st));
      if (strobe8) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL sample8: got %0d with no sample expected at %0t", out8, $time);
        end else begin
          e = q8.pop_front();
          $display("out  w8  sample=%0d expected=%0d edge=%0d", out8, e, cnt);
          if (int'(out8) != e) begin
            errors++;
            $display("FAIL sample8: got %0d expected %0d at %0t", out8, e, $time);
          end
          last8 = e;
        end
      end else begin
        chk("hold8", int'(out8), last8);
      end
      if (strobe10) begin
        checks++;
        if (q10.size() == 0) begin
          errors++;
          $display("FAIL sample10: got %0d with no sample expected at %0t", out10, $time);
        end else begin
          e = q10.pop_front();
          $display("out  w10 sample=%0d expected=%0d edge=%0d", out10, e, cnt);
          if (int'(out10) != e) begin
            errors++;
            $display("FAIL sample10: got %0d expected %0d at %0t", out10, e, $time);
          end
          last10 = e;
        end
      end else begin
        chk("hold10", int'(out10), last10);
      end
    end
  end

  // Driver
  initial begin
    //          c1  c2  c3  c4  en  vol mute at  gl  e8   e10
    vecs[0]  = '{15, 15, 15, 15, 15, 7,  0,  0,  0, 240, 960};
    vecs[1]  = '{ 8, 15, 15, 15,  1, 0,  0,  0,  0,   4,  16};
    vecs[2]  = '{ 8, 15,  6, 15,  5, 3,  0,  0,  0,  28, 112};
    vecs[3]  = '{15, 15, 15, 15, 15, 7,  0,  0,  1, 240, 960};
    vecs[4]  = '{15, 15, 15, 15, 15, 0,  0, 100, 0,  30, 120};
    vecs[5]  = '{15, 15, 15, 15, 15, 7,  0,  0,  0, 240, 960};
    vecs[6]  = '{15, 15, 15, 15, 15, 7,  1, 250, 0,   0,   0};
    vecs[7]  = '{15, 15, 15, 15, 15, 7,  0,  0,  0, 240, 960};
    vecs[8]  = '{ 1,  3,  5,  7, 14, 2,  0,  0,  0,  22,  90};
    vecs[9]  = '{ 1, 15, 15, 15,  1, 0,  0,  0,  0,   0,   2};
    vecs[10] = '{ 0,  0,  0, 15,  8, 7,  0,  0,  0,  60, 240};
    vecs[11] = '{15, 15, 15, 15, 15, 7,  0,  0,  0, 240, 960};
    vr       = '{ 2,  4,  6,  8, 15, 1,  0,  0,  0,  20,  80};

    reset_n = 1'b0;
    repeat (10) begin
      @(negedge clk);
      ch1 = 4'($urandom); ch2 = 4'($urandom); ch3 = 4'($urandom); ch4 = 4'($urandom);
      ch_enable = 4'($urandom); master_vol = 3'($urandom); mute = 1'($urandom);
    end
    apply(vecs[0]);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        while (cnt % DIV != vecs[i].at) @(negedge clk);
        apply(vecs[i]);
      end
      if (vecs[i].glitch != 0) begin
        while (cnt % DIV != 50) @(negedge clk);
        ch1 = ~ch1;
        @(negedge clk);
        ch1 = ~ch1;
      end
      wait_capture();
      q8.push_back(vecs[i].e8);
      q10.push_back(vecs[i].e10);
      $display("in   vec=%0d ch=%0d,%0d,%0d,%0d en=%h vol=%0d mute=%0d exp8=%0d exp10=%0d",
               i, ch1, ch2, ch3, ch4, ch_enable, master_vol, mute, vecs[i].e8, vecs[i].e10);
    end

    // Abort the sample just captured (vecs[11]) one clock into its pipeline.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out8", int'(out8), 0);
    chk("midrst_out10", int'(out10), 0);
    chk("midrst_strobe8", int'(strobe8), 0);
    repeat (3) @(negedge clk);
    apply(vr);
    reset_n = 1'b1;
    wait_capture();
    q8.push_back(vr.e8);
    q10.push_back(vr.e10);
    $display("in   vec=post_reset exp8=%0d exp10=%0d", vr.e8, vr.e10);

    for (int k = 0; k < 600 && (q8.size() != 0 || q10.size() != 0); k++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("drain_q8", q8.size(), 0);
    chk("drain_q10", q10.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
